// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fulladder cell reused LSB-first over WIDTH clocks.
// Optional subtract mode (Sub port) enabled by defining SERIAL_ADDER_SUB_EN.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ ci;
  assign co  = (a & b) | (axb & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg, opb_reg, res_reg, sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             load, last;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] opb_load;
  logic             carry_load;
  logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the carry-in to 1.
  assign opb_load   = Sub ? ~B : B;
  assign carry_load = Sub ? 1'b1 : Cin;
`else
  assign opb_load   = B;
  assign carry_load = Cin;
`endif

  fulladder u_fa (
    .a  (opa_reg[0]),
    .b  (opb_reg[0]),
    .ci (carry_reg),
    .s  (fa_sum),
    .co (fa_cout)
  );

  assign last      = (cnt_reg == CW'(WIDTH - 1));
  assign res_shift = {fa_sum, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A start is accepted from IDLE and also from DONE, giving back-to-back adds.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (load) begin
      opa_reg   <= A;
      opb_reg   <= opb_load;
      carry_reg <= carry_load;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      res_reg   <= res_shift;
      opa_reg   <= opa_reg >> 1;
      opb_reg   <= opb_reg >> 1;
      carry_reg <= fa_cout;
      // Counter parks at 0 on the last bit so it never wraps past WIDTH-1.
      cnt_reg   <= last ? '0 : cnt_reg + CW'(1);
      if (last) begin
        sum_reg  <= res_shift;
        cout_reg <= fa_cout;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign Sum  = sum_reg;
  assign Cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an arithmetic model.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         Sub = 1'b0;
  logic         busy, done, Cout;
  logic [W-1:0] Sum;

  int checks = 0;
  int failures = 0;

  // Last result the DUT should be holding on Sum/Cout.
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub   (Sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL async_reset busy=%b done=%b Sum=%h Cout=%b expected 0 0 00 0",
               busy, done, Sum, Cout);
    end
    step(); step();
    rst = 1'b0;
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b done=%b Sum=%h Cout=%b expected 0 0 00 0",
               busy, done, Sum, Cout);
    end
    $display("txn reset: busy=%b done=%b Sum=%h Cout=%b", busy, done, Sum, Cout);
  endtask

  task automatic test_add(input int n);
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W:0]   exp;
    bit           ok_busy, ok_hold;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        a = 8'h3C; b = 8'h5A; cin = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
`ifdef SERIAL_ADDER_SUB_EN
      sub = (i == 0) ? 1'b0 : 1'($urandom);
`else
      sub = 1'b0;
`endif
      exp = model(a, b, cin, sub);
      launch(a, b, cin, sub);
      ok_busy = 1'b1;
      ok_hold = 1'b1;
      for (int k = 0; k < W; k++) begin
        if (busy !== 1'b1 || done !== 1'b0) ok_busy = 1'b0;
        if (Sum !== exp_sum || Cout !== exp_cout) ok_hold = 1'b0;
        step();
      end
      checks++;
      if (!(ok_busy && done === 1'b1 && busy === 1'b0)) begin
        failures++;
        $display("FAIL latency txn=%0d busy_ok=%b done=%b busy=%b expected busy W cycles then done=1 busy=0",
                 i, ok_busy, done, busy);
      end
      checks++;
      if (!ok_hold) begin
        failures++;
        $display("FAIL hold txn=%0d Sum/Cout changed during run, expected %h/%b", i, exp_sum, exp_cout);
      end
      checks++;
      if (Sum !== exp[W-1:0] || Cout !== exp[W]) begin
        failures++;
        $display("FAIL result txn=%0d A=%h B=%h Cin=%b Sub=%b got Sum=%h Cout=%b expected Sum=%h Cout=%b",
                 i, a, b, cin, sub, Sum, Cout, exp[W-1:0], exp[W]);
      end
      $display("txn add %0d: A=%h B=%h Cin=%b Sub=%b -> Sum=%h Cout=%b", i, a, b, cin, sub, Sum, Cout);
      exp_sum  = exp[W-1:0];
      exp_cout = exp[W];
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse txn=%0d done=%b busy=%b expected 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== 8'h00 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first done=%b Sum=%h Cout=%b expected 1 00 1", done, Sum, Cout);
    end
    $display("txn b2b first: A=ff B=01 Cin=0 -> Sum=%h Cout=%b", Sum, Cout);
    launch(8'hFF, 8'hFF, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_gap busy=%b done=%b expected 1 0", busy, done);
    end
    for (int k = 0; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== 8'hFF || Cout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second done=%b Sum=%h Cout=%b expected 1 ff 1", done, Sum, Cout);
    end
    $display("txn b2b second: A=ff B=ff Cin=1 -> Sum=%h Cout=%b", Sum, Cout);
    step();
  endtask

  task automatic test_ignore_start();
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    step(); step();
    A = 8'hAA; B = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 3; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== 8'h02 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start done=%b Sum=%h Cout=%b expected 1 02 0", done, Sum, Cout);
    end
    $display("txn ignore: A=01 B=01 (AA/55 dropped) -> Sum=%h Cout=%b", Sum, Cout);
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_not_queued busy=%b done=%b expected 0 0", busy, done);
    end
    exp_sum = 8'h02; exp_cout = 1'b0;
  endtask

  task automatic test_abort();
    logic [W-1:0] a, b;
    logic         cin;
    logic [W:0]   exp;
    bit           saw;
    launch(8'h3C, 8'h5A, 1'b0, 1'b0);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Sum !== 8'h00 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL abort busy=%b done=%b Sum=%h Cout=%b expected 0 0 00 0", busy, done, Sum, Cout);
    end
    step(); step();
    rst = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
      step();
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL abort_no_done activity seen after abort, expected none");
    end
    $display("txn abort: outputs cleared Sum=%h Cout=%b", Sum, Cout);
    exp_sum = '0; exp_cout = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    exp = model(a, b, cin, 1'b0);
    launch(a, b, cin, 1'b0);
    for (int k = 0; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== exp[W-1:0] || Cout !== exp[W]) begin
      failures++;
      $display("FAIL after_abort A=%h B=%h Cin=%b done=%b Sum=%h Cout=%b expected 1 %h %b",
               a, b, cin, done, Sum, Cout, exp[W-1:0], exp[W]);
    end
    $display("txn post-abort: A=%h B=%h Cin=%b -> Sum=%h Cout=%b", a, b, cin, Sum, Cout);
    exp_sum = exp[W-1:0]; exp_cout = exp[W];
    step();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    launch(8'h10, 8'h20, 1'b1, 1'b1);
    for (int k = 0; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== 8'hF0 || Cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow done=%b Sum=%h Cout=%b expected 1 f0 0", done, Sum, Cout);
    end
    $display("txn sub: 10-20 -> Sum=%h Cout=%b", Sum, Cout);
    launch(8'h20, 8'h10, 1'b0, 1'b1);
    for (int k = 0; k < W; k++) step();
    checks++;
    if (done !== 1'b1 || Sum !== 8'h10 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_noborrow done=%b Sum=%h Cout=%b expected 1 10 1", done, Sum, Cout);
    end
    $display("txn sub: 20-10 -> Sum=%h Cout=%b", Sum, Cout);
    exp_sum = 8'h10; exp_cout = 1'b1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_add(24);
    test_back_to_back();
    test_ignore_start();
    test_abort();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_add(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
